// File: rtl/ahb_ctrl_seq_pkg.sv
// ahb_ctrl_seq_pkg
// Shared definitions for the AHB control-pattern sequencer:
//   - register offsets (decoded on HADDR[15:0])
//   - CTRL / STATUS bit positions
//   - pattern width (6) and hold-count width (16)
//   - FSM state encoding
//   - command entry layout and the hold-load helper
// Optional feature macro used by the top level: CTRL_SEQ_LOOP_EN.
package ahb_ctrl_seq_pkg;

    localparam int PAT_W  = 6;
    localparam int HOLD_W = 16;

    localparam logic [15:0] OFS_CMD    = 16'h0000;
    localparam logic [15:0] OFS_CTRL   = 16'h0004;
    localparam logic [15:0] OFS_STATUS = 16'h0008;
    localparam logic [15:0] OFS_IDLE   = 16'h000C;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_FLUSH_BIT = 1;
    localparam int CTRL_IRQEN_BIT = 2;
    localparam int CTRL_LOOP_BIT  = 3;

    localparam int ST_BUSY_BIT  = 0;
    localparam int ST_EMPTY_BIT = 1;
    localparam int ST_FULL_BIT  = 2;
    localparam int ST_OVF_BIT   = 3;
    localparam int ST_DONE_BIT  = 4;
    localparam int ST_LVL_LSB   = 8;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    typedef struct packed {
        logic [HOLD_W-1:0] hold;
        logic [PAT_W-1:0]  pat;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    // A hold of zero still shows its pattern for one cycle.
    function automatic logic [HOLD_W-1:0] hold_load(input logic [HOLD_W-1:0] h);
        return (h == '0) ? HOLD_W'(1) : h;
    endfunction

endpackage

// File: rtl/ctrl_seq_fifo.sv
// ctrl_seq_fifo
// Synchronous command FIFO with push, pop and flush.
// Ports:
//   AHB_HCLK, AHB_HRESETn    clock, asynchronous active-low reset
//   push_i, wdata_i          write request and data (accepted when not full,
//                            or when a pop happens in the same cycle)
//   pop_i                    remove head entry (ignored when empty)
//   flush_i                  empty the FIFO; overrides push and pop
//   rdata_o                  head entry (valid when !empty_o)
//   full_o, empty_o, level_o occupancy flags and count
module ctrl_seq_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 22,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             AHB_HCLK,
    input  logic             AHB_HRESETn,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok = push_i & (~full_o | pop_i);
    assign pop_ok  = pop_i & ~empty_o;

    always_ff @(posedge AHB_HCLK or negedge AHB_HRESETn) begin
        if (!AHB_HRESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_q + LW'(push_ok) - LW'(pop_ok);
        end
    end

    // Storage needs no reset: entries are only read once the level says so.
    always_ff @(posedge AHB_HCLK) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/ahb_ctrl_sequencer.sv
// ahb_ctrl_sequencer
// AHB-Lite slave that plays queued control patterns onto game-controller
// outputs. Each command is {hold[15:0], pattern[5:0]}; a pattern is shown for
// max(hold,1) cycles, commands chain with no gap, and the IDLE pattern is
// driven whenever nothing is playing.
// Ports:
//   AHB_HCLK, AHB_HRESETn   clock, asynchronous active-low reset
//   AHB_HSEL..AHB_HWDATA    AHB-Lite slave inputs (size/burst/prot/master/lock ignored)
//   AHB_HRDATA/HREADY/HRESP read data, always ready, always OKAY
//   ctrl_btn, ctrl_sw       pattern bits [1:0], [3:2]
//   ctrl_str, ctrl_img      pattern bits 4, 5
//   seq_busy                a command is being held
//   seq_irq                 irq_en & (done | overflow)
// Bus handshake: zero wait states; the address phase is registered every
// cycle and the following cycle is a valid data phase when the registered
// HSEL, HWRITE/!HWRITE and HTRANS[1] are all set.
// Optional: define CTRL_SEQ_LOOP_EN to recirculate popped commands (CTRL.loop).
module ahb_ctrl_sequencer
    import ahb_ctrl_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        AHB_HCLK,
    input  logic        AHB_HRESETn,
    input  logic        AHB_HSEL,
    input  logic        AHB_HWRITE,
    input  logic [1:0]  AHB_HTRANS,
    input  logic [2:0]  AHB_HSIZE,
    input  logic [2:0]  AHB_HBURST,
    input  logic [3:0]  AHB_HPROT,
    input  logic [3:0]  AHB_HMASTER,
    input  logic        AHB_HMASTLOCK,
    input  logic [31:0] AHB_HADDR,
    input  logic [31:0] AHB_HWDATA,
    output logic [31:0] AHB_HRDATA,
    output logic        AHB_HREADY,
    output logic [1:0]  AHB_HRESP,
    output logic [1:0]  ctrl_btn,
    output logic [1:0]  ctrl_sw,
    output logic        ctrl_str,
    output logic        ctrl_img,
    output logic        seq_busy,
    output logic        seq_irq
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    // Address phase capture
    logic [15:0] addr_q;
    logic        write_q, sel_q, trans_q;

    always_ff @(posedge AHB_HCLK or negedge AHB_HRESETn) begin
        if (!AHB_HRESETn) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            sel_q   <= 1'b0;
            trans_q <= 1'b0;
        end else begin
            addr_q  <= AHB_HADDR[15:0];
            write_q <= AHB_HWRITE;
            sel_q   <= AHB_HSEL;
            trans_q <= AHB_HTRANS[1];
        end
    end

    logic wr_valid, rd_valid;
    logic wr_cmd, wr_ctrl, wr_status, wr_idle, flush;

    assign wr_valid  = sel_q & trans_q & write_q;
    assign rd_valid  = sel_q & trans_q & ~write_q;
    assign wr_cmd    = wr_valid & (addr_q == OFS_CMD);
    assign wr_ctrl   = wr_valid & (addr_q == OFS_CTRL);
    assign wr_status = wr_valid & (addr_q == OFS_STATUS);
    assign wr_idle   = wr_valid & (addr_q == OFS_IDLE);
    assign flush     = wr_ctrl & AHB_HWDATA[CTRL_FLUSH_BIT];

    // Sequencer state
    logic [0:0]        state_q, state_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [PAT_W-1:0]  out_q, out_d;
    logic [PAT_W-1:0]  idle_q;
    logic              enable_q, irq_en_q, done_q, ovf_q;
    logic              done_set;
    logic              loop_rd;

    // FIFO interface
    cmd_t          f_head, f_wdata, cmd_in;
    logic          f_push, f_full, f_empty;
    logic [LW-1:0] f_level;
    logic          pop_req, cmd_push, cmd_drop, recirc;

    assign cmd_in.hold = AHB_HWDATA[31:16];
    assign cmd_in.pat  = AHB_HWDATA[PAT_W-1:0];

    // Flush aborts everything, so it also suppresses the pop.
    assign pop_req = enable_q & ~f_empty & ~flush &
                     ((state_q == S_IDLE) | ((state_q == S_HOLD) & (cnt_q == HOLD_W'(1))));

    assign cmd_push = wr_cmd & ~flush;

`ifdef CTRL_SEQ_LOOP_EN
    logic loop_q;
    assign recirc  = pop_req & loop_q;
    assign loop_rd = loop_q;
`else
    assign recirc  = 1'b0;
    assign loop_rd = 1'b0;
`endif

    // The recirculated command owns the single write port; a bus push that
    // collides with it, or hits a full FIFO with no pop, is lost.
    assign cmd_drop = cmd_push & (recirc | (f_full & ~pop_req));
    assign f_push   = recirc | (cmd_push & ~cmd_drop);
    assign f_wdata  = recirc ? f_head : cmd_in;

    ctrl_seq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .AHB_HCLK    (AHB_HCLK),
        .AHB_HRESETn (AHB_HRESETn),
        .push_i      (f_push),
        .pop_i       (pop_req),
        .flush_i     (flush),
        .wdata_i     (f_wdata),
        .rdata_o     (f_head),
        .full_o      (f_full),
        .empty_o     (f_empty),
        .level_o     (f_level)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        done_set = 1'b0;
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            out_d   = idle_q;
        end else if (pop_req) begin
            state_d = S_HOLD;
            cnt_d   = hold_load(f_head.hold);
            out_d   = f_head.pat;
        end else if (state_q == S_HOLD) begin
            if (cnt_q == HOLD_W'(1)) begin
                state_d  = S_IDLE;
                cnt_d    = '0;
                out_d    = idle_q;
                done_set = 1'b1;
            end else begin
                cnt_d = cnt_q - HOLD_W'(1);
            end
        end else begin
            // Idle output follows the IDLE register.
            out_d = idle_q;
        end
    end

    always_ff @(posedge AHB_HCLK or negedge AHB_HRESETn) begin
        if (!AHB_HRESETn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            out_q    <= '0;
            idle_q   <= '0;
            enable_q <= 1'b0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            if (wr_idle) idle_q <= AHB_HWDATA[PAT_W-1:0];
            if (wr_ctrl) begin
                enable_q <= AHB_HWDATA[CTRL_EN_BIT];
                irq_en_q <= AHB_HWDATA[CTRL_IRQEN_BIT];
            end
            // A new event wins over a same-cycle W1C.
            done_q <= done_set | (done_q & ~(wr_status & AHB_HWDATA[ST_DONE_BIT]));
            ovf_q  <= cmd_drop | (ovf_q  & ~(wr_status & AHB_HWDATA[ST_OVF_BIT]));
        end
    end

`ifdef CTRL_SEQ_LOOP_EN
    always_ff @(posedge AHB_HCLK or negedge AHB_HRESETn) begin
        if (!AHB_HRESETn)  loop_q <= 1'b0;
        else if (wr_ctrl)  loop_q <= AHB_HWDATA[CTRL_LOOP_BIT];
    end
`endif

    // Read data
    always_comb begin
        AHB_HRDATA = '1;
        if (rd_valid) begin
            case (addr_q)
                OFS_CTRL: begin
                    AHB_HRDATA                 = '0;
                    AHB_HRDATA[CTRL_EN_BIT]    = enable_q;
                    AHB_HRDATA[CTRL_IRQEN_BIT] = irq_en_q;
                    AHB_HRDATA[CTRL_LOOP_BIT]  = loop_rd;
                end
                OFS_STATUS: begin
                    AHB_HRDATA                         = '0;
                    AHB_HRDATA[ST_BUSY_BIT]            = (state_q == S_HOLD);
                    AHB_HRDATA[ST_EMPTY_BIT]           = f_empty;
                    AHB_HRDATA[ST_FULL_BIT]            = f_full;
                    AHB_HRDATA[ST_OVF_BIT]             = ovf_q;
                    AHB_HRDATA[ST_DONE_BIT]            = done_q;
                    AHB_HRDATA[ST_LVL_LSB +: 4]        = 4'(f_level);
                end
                OFS_IDLE: begin
                    AHB_HRDATA              = '0;
                    AHB_HRDATA[PAT_W-1:0]   = idle_q;
                end
                default: AHB_HRDATA = '1;
            endcase
        end
    end

    assign AHB_HREADY = 1'b1;
    assign AHB_HRESP  = 2'b00;

    assign ctrl_btn = out_q[1:0];
    assign ctrl_sw  = out_q[3:2];
    assign ctrl_str = out_q[4];
    assign ctrl_img = out_q[5];
    assign seq_busy = (state_q == S_HOLD);
    assign seq_irq  = irq_en_q & (done_q | ovf_q);

    logic unused_inputs;
    assign unused_inputs = ^{AHB_HSIZE, AHB_HBURST, AHB_HPROT, AHB_HMASTER, AHB_HMASTLOCK,
                             AHB_HADDR[31:16], AHB_HTRANS[0], AHB_HWDATA[15:6]};

endmodule

// File: doc/ahb_ctrl_sequencer.md
AHB_CTRL_SEQUENCER -- requirements
Module: ahb_ctrl_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, command FIFO entries; legal values 2, 4, 8.
REQ-002 SHALL have ports, in this order:
- AHB_HCLK  in  1  clock.
- AHB_HRESETn  in  1  reset, asynchronous, active-low.
- AHB_HSEL, AHB_HWRITE  in  1  slave select; write.
- AHB_HTRANS  in  2  transfer type.
- AHB_HSIZE, AHB_HBURST  in  3  ignored.
- AHB_HPROT, AHB_HMASTER  in  4  ignored.
- AHB_HMASTLOCK  in  1  ignored.
- AHB_HADDR, AHB_HWDATA  in  32  address; write data.
- AHB_HRDATA  out  32  read data.
- AHB_HREADY  out  1  ready.
- AHB_HRESP  out  2  response.
- ctrl_btn, ctrl_sw  out  2  direction buttons; paddle-length switches.
- ctrl_str, ctrl_img  out  1  start/pause; menu/game view select.
- seq_busy  out  1  command executing.
- seq_irq  out  1  interrupt, level.
REQ-003 SHALL use AHB_HRESETn as asynchronous active-low reset and AHB_HCLK as the only clock.

Function
REQ-004 SHALL drive AHB_HREADY=1 and AHB_HRESP=2'b00 at all times (zero wait states).
REQ-005 SHALL register HADDR, HWRITE, HSEL and HTRANS[1] in the address phase; a write/read is valid in the following data phase when all three registered qualifiers are 1.
REQ-006 SHALL decode address bits [15:0]:
- 0x00 CMD (W): push {HWDATA[31:16] hold, HWDATA[5:0] pattern}.
- 0x04 CTRL (RW): bit0 enable, bit1 flush (self-clearing, reads 0), bit2 irq_en, bit3 loop.
- 0x08 STATUS (R; W1C bits 3,4): bit0 busy, bit1 empty, bit2 full, bit3 overflow, bit4 done, [11:8] level.
- 0x0C IDLE (RW): [5:0] idle pattern.
REQ-007 SHALL map a pattern as bits[1:0] ctrl_btn, [3:2] ctrl_sw, bit4 ctrl_str, bit5 ctrl_img.
REQ-008 SHALL drive HRDATA combinationally from the registered address in a valid read; unmapped offsets, CMD, and non-read cycles SHALL return 32'hFFFFFFFF; unused register bits SHALL read 0.
REQ-009 SHALL implement FSM states IDLE and HOLD.
REQ-010 SHALL pop a command when enable=1, FIFO non-empty, and either state=IDLE or (state=HOLD and hold counter=1).
REQ-011 SHALL, on pop, load the output register with the pattern and the counter with max(hold,1), entering HOLD; the pattern appears the cycle after the pop and persists exactly max(hold,1) cycles.
REQ-012 SHALL chain back-to-back commands with no idle-pattern gap.
REQ-013 SHALL, when HOLD expires with no pop, return to IDLE, drive the IDLE pattern the next cycle, and set sticky done.
REQ-014 SHALL hold seq_busy=1 exactly while state=HOLD.
REQ-015 SHALL, on CMD write while full with no simultaneous pop, drop the command and set sticky overflow; a simultaneous pop SHALL free the slot and the push SHALL be accepted.
REQ-016 SHALL, on flush, empty the FIFO, abort HOLD to IDLE, and drive the IDLE pattern the next cycle without setting done; flush SHALL win over a same-cycle CMD push (discarded, no overflow).
REQ-017 SHALL, on enable cleared during HOLD, complete the current command and then stop popping.
REQ-018 SHALL drive seq_irq = irq_en & (done | overflow).

Reset
REQ-019 SHALL reset FIFO to empty, state IDLE, counter 0, CTRL=0, IDLE register=0, done=overflow=0, all ctrl_* outputs 0, seq_busy=0, seq_irq=0.
REQ-020 SHALL, on reset asserted mid-HOLD, take all outputs to reset values immediately (asynchronously).

Configuration
REQ-021 SHALL, with CTRL_SEQ_LOOP_EN defined, re-push each popped command to the FIFO tail when CTRL.loop=1 (level unchanged); a same-cycle CMD push SHALL be dropped with overflow set.
REQ-022 SHALL, without CTRL_SEQ_LOOP_EN, read CTRL bit3 as 0 and ignore writes to it.

Structure
REQ-023 SHALL place the following in shared package ahb_ctrl_seq_pkg: register offsets, CTRL/STATUS bit positions, pattern width (6), hold width (16), FSM state encoding.
REQ-024 SHALL instantiate one sub-module, ctrl_seq_fifo: a synchronous FIFO with push/pop/flush and full/empty/level outputs.

Verification
REQ-025 SHALL cover: CMD 0x0003_0011, IDLE=0x00, enable -> pattern 0x11 on outputs 3 cycles; done=1; IDLE pattern afterwards.
REQ-026 SHALL cover: two CMDs hold 2 and hold 0 -> 2 cycles then 1 cycle, no gap; busy high 3 cycles.
REQ-027 SHALL cover: enable=0, 9 pushes at FIFO_DEPTH=8 -> full=1, level=8, overflow=1; W1C 0x08 -> overflow=0.
REQ-028 SHALL cover: flush during 100-cycle hold with 3 queued -> IDLE next cycle, empty=1, done=0.
REQ-029 SHALL cover: irq_en=1 with done set -> seq_irq=1; reset mid-hold -> all outputs 0.
REQ-030 SHALL cover (CTRL_SEQ_LOOP_EN): loop=1 with 2 commands -> sequence A,B,A,B repeats; level stays 2.
